// File: rtl/imem_refill_ctrl_if.sv
// imem_refill_ctrl_if: cache-side miss/word signals plus the memory request/grant/response handshake
interface imem_refill_ctrl_if #(
    parameter int PC_SIZE  = 32,
    parameter int MEM_WORD = 8
);
    logic                cache_miss;
    logic [PC_SIZE-1:0]  ram_address;
    logic                mem_req;
    logic [PC_SIZE-1:0]  mem_addr;
    logic                mem_gnt;
    logic                mem_rvalid;
    logic [MEM_WORD-1:0] mem_rdata;
    logic                word_ready;
    logic [MEM_WORD-1:0] mem_word;
    logic                busy;
    logic                refill_done;
    modport master (
        input  cache_miss, ram_address, mem_gnt, mem_rvalid, mem_rdata,
        output mem_req, mem_addr, word_ready, mem_word, busy, refill_done
    );
    modport slave (
        output cache_miss, ram_address, mem_gnt, mem_rvalid, mem_rdata,
        input  mem_req, mem_addr, word_ready, mem_word, busy, refill_done
    );
endinterface

// File: rtl/imem_refill_ctrl.sv
// imem_refill_ctrl: on a cache miss, fetches the aligned block one word at a time and streams it to the cache
module imem_refill_ctrl #(
    parameter int PC_SIZE    = 32,
    parameter int MEM_WORD   = 8,
    parameter int BLOCK_BITS = 512
) (
    input logic                clk,
    input logic                nrst,
    imem_refill_ctrl_if.master bus
);
    localparam int WORDS = BLOCK_BITS / MEM_WORD;
    localparam int CW    = $clog2(WORDS);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t              state, state_n;
    logic [CW-1:0]       cnt, cnt_n, cnt_inc;
    logic [PC_SIZE-1:0]  blk_addr, blk_addr_n, mem_addr, mem_addr_n;
    logic [MEM_WORD-1:0] mem_word, mem_word_n;
    logic                mem_req, mem_req_n, word_ready, word_ready_n;
    logic                refill_done, refill_done_n, busy, same_blk;
    assign cnt_inc  = cnt + 1'b1;
    assign same_blk = bus.ram_address == blk_addr;
    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        blk_addr_n    = blk_addr;
        mem_addr_n    = mem_addr;
        mem_word_n    = mem_word;
        mem_req_n     = mem_req;
        word_ready_n  = 1'b0;
        refill_done_n = 1'b0;
        case (state)
            IDLE: if (bus.cache_miss) begin
                state_n    = REQ;
                blk_addr_n = bus.ram_address;
                cnt_n      = '0;
                mem_req_n  = 1'b1;
                mem_addr_n = bus.ram_address;
            end
            REQ: if (bus.mem_gnt) begin
                state_n   = WAIT;
                mem_req_n = 1'b0;
            end
            WAIT: if (bus.mem_rvalid) begin
                // a changed miss address means this block is no longer wanted
                if (!same_blk) state_n = IDLE;
                else begin
                    mem_word_n   = bus.mem_rdata;
                    word_ready_n = 1'b1;
                    if (cnt == CW'(WORDS - 1)) begin
                        refill_done_n = 1'b1;
                        state_n       = DONE;
                    end else begin
                        cnt_n      = cnt_inc;
                        state_n    = REQ;
                        mem_req_n  = 1'b1;
                        mem_addr_n = blk_addr + PC_SIZE'(cnt_inc) * PC_SIZE'(MEM_WORD / 8);
                    end
                end
            end
            default: if (!bus.cache_miss || !same_blk) state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= IDLE;
            cnt         <= '0;
            blk_addr    <= '0;
            mem_addr    <= '0;
            mem_word    <= '0;
            mem_req     <= 1'b0;
            word_ready  <= 1'b0;
            refill_done <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            blk_addr    <= blk_addr_n;
            mem_addr    <= mem_addr_n;
            mem_word    <= mem_word_n;
            mem_req     <= mem_req_n;
            word_ready  <= word_ready_n;
            refill_done <= refill_done_n;
            busy        <= state_n != IDLE;
        end
    end
    assign bus.mem_req     = mem_req;
    assign bus.mem_addr    = mem_addr;
    assign bus.word_ready  = word_ready;
    assign bus.mem_word    = mem_word;
    assign bus.busy        = busy;
    assign bus.refill_done = refill_done;
endmodule

// File: tb/tb_imem_refill_ctrl.sv
// tb_imem_refill_ctrl: scoreboard bench driving the memory handshake and checking the delivered word stream
module tb_imem_refill_ctrl;
    logic clk = 1'b0;
    logic nrst = 1'b0;
    int vectors = 0;
    int errors = 0;
    int cyc = 0;
    int words_seen = 0;
    logic [7:0] exp_q[$];
    imem_refill_ctrl_if #(.PC_SIZE(32), .MEM_WORD(8)) bus ();
    imem_refill_ctrl #(.PC_SIZE(32), .MEM_WORD(8), .BLOCK_BITS(512)) dut (
        .clk(clk),
        .nrst(nrst),
        .bus(bus.master)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cache_miss  = 1'b0;
        bus.ram_address = '0;
        bus.mem_gnt     = 1'b0;
        bus.mem_rvalid  = 1'b0;
        bus.mem_rdata   = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        nrst = 1'b0;
        tick();
        tick();
        nrst = 1'b1;
        tick();
        exp_q.delete();
        words_seen = 0;
    endtask

    // expects the request for this word to be visible now; grants after 'stall' cycles, answers next cycle
    task automatic serve_word(input logic [31:0] addr, input logic [7:0] data, input int stall, input bit last);
        logic [7:0] exp;
        for (int i = 0; i <= stall; i++) begin
            vectors++;
            if (bus.mem_req !== 1'b1 || bus.mem_addr !== addr) begin
                errors++;
                $display("FAIL req: mem_req=%b mem_addr=%h, required 1/%h", bus.mem_req, bus.mem_addr, addr);
            end
            bus.mem_gnt = (i == stall);
            tick();
        end
        bus.mem_gnt = 1'b0;
        vectors++;
        if (bus.mem_req !== 1'b0 || bus.word_ready !== 1'b0) begin
            errors++;
            $display("FAIL wait: mem_req=%b word_ready=%b, required 0/0", bus.mem_req, bus.word_ready);
        end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = data;
        exp_q.push_back(data);
        tick();
        bus.mem_rvalid = 1'b0;
        vectors++;
        if (bus.word_ready !== 1'b1) begin
            errors++;
            $display("FAIL word_ready: got %b, required 1 (addr %h)", bus.word_ready, addr);
        end else begin
            words_seen++;
            exp = exp_q.pop_front();
            if (bus.mem_word !== exp) begin
                errors++;
                $display("FAIL mem_word: got %h, required %h", bus.mem_word, exp);
            end
        end
        vectors++;
        if (bus.refill_done !== last || bus.busy !== 1'b1 || bus.mem_req !== !last) begin
            errors++;
            $display("FAIL deliver: refill_done=%b busy=%b mem_req=%b, required %b/1/%b",
                     bus.refill_done, bus.busy, bus.mem_req, last, !last);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        nrst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.cache_miss  = 1'($urandom);
            bus.ram_address = $urandom;
            bus.mem_gnt     = 1'($urandom);
            bus.mem_rvalid  = 1'($urandom);
            bus.mem_rdata   = 8'($urandom);
            tick();
            vectors++;
            if ({bus.mem_req, bus.mem_addr, bus.word_ready, bus.mem_word, bus.busy, bus.refill_done} !== '0) begin
                errors++;
                $display("FAIL reset_hold: req=%b addr=%h wr=%b word=%h busy=%b done=%b, required all 0",
                         bus.mem_req, bus.mem_addr, bus.word_ready, bus.mem_word, bus.busy, bus.refill_done);
            end
        end
        idle_inputs();
        nrst = 1'b1;
        tick();
        vectors++;
        if (bus.mem_req !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: mem_req=%b busy=%b, required 0/0", bus.mem_req, bus.busy);
        end
    endtask

    task automatic test_zero_wait();
        int c0;
        apply_reset();
        bus.ram_address = 32'h0000_1040;
        bus.cache_miss  = 1'b1;
        tick();
        c0 = cyc;
        vectors++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_rise: got %b, required 1", bus.busy);
        end
        for (int k = 0; k < 64; k++) serve_word(32'h1040 + k, 8'(k + 'hA0), 0, k == 63);
        vectors++;
        if (cyc - c0 != 128) begin
            errors++;
            $display("FAIL refill_len: got %0d cycles, required 128", cyc - c0);
        end
        vectors++;
        if (words_seen != 64 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL zero_wait_count: got %0d words (%0d pending), required 64 (0)", words_seen, exp_q.size());
        end
        bus.cache_miss = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        apply_reset();
        bus.ram_address = 32'h0000_1040;
        bus.cache_miss  = 1'b1;
        tick();
        for (int k = 0; k < 64; k++) serve_word(32'h1040 + k, 8'(k + 'hA0), (k == 3) ? 5 : 0, k == 63);
        vectors++;
        if (words_seen != 64 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL backpressure_count: got %0d words (%0d pending), required 64 (0)", words_seen, exp_q.size());
        end
        bus.cache_miss = 1'b0;
        tick();
    endtask

    task automatic test_stale();
        apply_reset();
        bus.ram_address = 32'h0000_1040;
        bus.cache_miss  = 1'b1;
        tick();
        for (int k = 0; k <= 10; k++) serve_word(32'h1040 + k, 8'(k + 'hA0), 0, 1'b0);
        vectors++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h104B) begin
            errors++;
            $display("FAIL stale_req: mem_req=%b mem_addr=%h, required 1/0000104b", bus.mem_req, bus.mem_addr);
        end
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt     = 1'b0;
        bus.ram_address = 32'h0000_2000;
        bus.mem_rvalid  = 1'b1;
        bus.mem_rdata   = 8'hEE;
        tick();
        bus.mem_rvalid = 1'b0;
        vectors++;
        if (bus.word_ready !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL stale_drop: word_ready=%b busy=%b, required 0/0", bus.word_ready, bus.busy);
        end
        tick();
        serve_word(32'h2000, 8'h55, 0, 1'b0);
        serve_word(32'h2001, 8'h56, 0, 1'b0);
        vectors++;
        if (words_seen != 13) begin
            errors++;
            $display("FAIL stale_count: got %0d words, required 13", words_seen);
        end
    endtask

    task automatic test_done_hold();
        apply_reset();
        bus.ram_address = 32'h0000_0800;
        bus.cache_miss  = 1'b1;
        tick();
        for (int k = 0; k < 64; k++) serve_word(32'h0800 + k, 8'(k) ^ 8'h3C, 0, k == 63);
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (bus.mem_req !== 1'b0 || bus.busy !== 1'b1 || bus.refill_done !== 1'b0 || bus.word_ready !== 1'b0) begin
                errors++;
                $display("FAIL done_hold: req=%b busy=%b done=%b wr=%b, required 0/1/0/0",
                         bus.mem_req, bus.busy, bus.refill_done, bus.word_ready);
            end
        end
        bus.cache_miss = 1'b0;
        tick();
        vectors++;
        if (bus.busy !== 1'b0 || bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL done_exit: busy=%b mem_req=%b, required 0/0", bus.busy, bus.mem_req);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        bus.ram_address = 32'h0000_1040;
        bus.cache_miss  = 1'b1;
        tick();
        for (int k = 0; k < 30; k++) serve_word(32'h1040 + k, 8'(k + 'hA0), 0, 1'b0);
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        #2 nrst = 1'b0;
        #1;
        vectors++;
        if ({bus.mem_req, bus.mem_addr, bus.word_ready, bus.mem_word, bus.busy, bus.refill_done} !== '0) begin
            errors++;
            $display("FAIL async_reset: req=%b addr=%h wr=%b word=%h busy=%b done=%b, required all 0",
                     bus.mem_req, bus.mem_addr, bus.word_ready, bus.mem_word, bus.busy, bus.refill_done);
        end
        bus.cache_miss = 1'b0;
        tick();
        tick();
        nrst           = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 8'hBE;
        tick();
        bus.mem_rvalid = 1'b0;
        vectors++;
        if (bus.word_ready !== 1'b0 || bus.busy !== 1'b0 || bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL late_rvalid: word_ready=%b busy=%b mem_req=%b, required 0/0/0",
                     bus.word_ready, bus.busy, bus.mem_req);
        end
        tick();
        vectors++;
        if (bus.word_ready !== 1'b0 || bus.mem_word !== 8'h00) begin
            errors++;
            $display("FAIL late_rvalid_word: word_ready=%b mem_word=%h, required 0/00", bus.word_ready, bus.mem_word);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        test_reset();
        test_zero_wait();
        test_backpressure();
        test_stale();
        test_done_hold();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/imem_refill_ctrl.md
# imem_refill_ctrl

Refill engine between the instruction memory and the instruction-cache controller. On a cache miss it latches the 64-byte-aligned block address and issues one memory read per word over a request/grant/response handshake. It then streams each returned word to the cache controller as a one-cycle `word_ready` pulse with `mem_word`. It sits directly upstream of the cache controller and supplies its `mem_word`/`word_ready` inputs from its `ram_address`/`cache_miss` outputs.

## Interface
- `PC_SIZE`, 32, width of `ram_address` and `mem_addr`.
- `MEM_WORD`, 8, bits per memory word; must be a multiple of 8.
- `BLOCK_BITS`, 512, cache block size in bits; `WORDS = BLOCK_BITS/MEM_WORD` (64 by default).
- `clk` in 1: single clock, all state on rising edge.
- `nrst` in 1: asynchronous, active-low reset.
- `cache_miss` in 1: the cache controller reports a miss for the current PC.
- `ram_address` in PC_SIZE: block-aligned miss address from the cache controller (low 6 bits zero).
- `mem_req` out 1: read request to instruction memory.
- `mem_addr` out PC_SIZE: byte address of the requested word.
- `mem_gnt` in 1: the memory accepts the request this cycle.
- `mem_rvalid` in 1: read data valid; at most one response per granted request.
- `mem_rdata` in MEM_WORD: read data.
- `word_ready` out 1: one-cycle pulse; `mem_word` holds the next word of the block.
- `mem_word` out MEM_WORD: word delivered to the cache controller.
- `busy` out 1: a refill is in progress (state is not IDLE).
- `refill_done` out 1: one-cycle pulse when the last word of a block is delivered.

## Operation
- State machine states: IDLE, REQ, WAIT, DONE. Word counter `cnt` is log2(WORDS) bits wide. Block register `blk_addr` is PC_SIZE bits wide.
- IDLE: if `cache_miss`=1, latch `blk_addr`=`ram_address`, set `cnt`=0, go to REQ. Otherwise stay in IDLE.
- REQ: `mem_req`=1 and `mem_addr`=`blk_addr` + `cnt`·(MEM_WORD/8), truncated to PC_SIZE. On `mem_gnt`=1, go to WAIT. Otherwise hold the request with a stable address.
- WAIT: `mem_req`=0; wait for `mem_rvalid`. On `mem_rvalid`:
  - Stale case: if `ram_address` differs from `blk_addr`, discard the data (no `word_ready`) and go to IDLE. IDLE relatches on the next miss.
  - Normal case: register `mem_rdata` into `mem_word` and pulse `word_ready` the next cycle. If `cnt`=WORDS-1, pulse `refill_done` with that word and go to DONE. Otherwise increment `cnt` and go to REQ.
- DONE: gives the cache time to write the block and raise its hit.
  - Go to IDLE when `cache_miss`=0, or when `ram_address` differs from `blk_addr` (a new miss).
  - While in DONE with `cache_miss`=1 and the same address, issue no requests.
- Only one request is outstanding at a time. `mem_rvalid` in IDLE, REQ or DONE is ignored.
- `mem_word` holds its last value between pulses; it is only updated on delivery.

## Timing
- Reset values: `mem_req`=0, `mem_addr`=0, `word_ready`=0, `mem_word`=0, `busy`=0, `refill_done`=0, state=IDLE, `cnt`=0, `blk_addr`=0.
- Reset mid-refill aborts immediately. Responses arriving after reset release are dropped (IDLE ignores them).
- All outputs are driven from flops; none depends combinationally on any input.
- Miss to first request:
  - `cache_miss` is sampled high at edge N.
  - `mem_req`=1 during cycle N+1.
- Per-word latency:
  - Grant at edge G; `mem_rvalid` is earliest at edge G+1.
  - `word_ready` is high during the cycle after the `mem_rvalid` edge.
  - The next `mem_req` is asserted in that same cycle.
- Minimum refill length with zero-wait memory: 2·WORDS cycles (128 by default).
- `word_ready` is never high on two consecutive cycles.
- `refill_done` is coincident with the WORDS-th `word_ready`.
- `busy` rises the cycle after the miss is latched. It falls the cycle after DONE exits.

## Test plan
- Reset: hold `nrst`=0, toggle all inputs → every output stays 0. Release with `cache_miss`=0 → IDLE, `mem_req`=0.
- Zero-wait refill: `ram_address`=0x0000_1040, `cache_miss`=1, grant same cycle, `mem_rvalid` next cycle with `mem_rdata`=cnt+0xA0 →
  - `mem_addr` steps 0x1040…0x107F.
  - 64 `word_ready` pulses carrying 0xA0…0xDF.
  - `refill_done` on pulse 64.
  - Refill spans 128 cycles.
- Backpressure: hold `mem_gnt`=0 for 5 cycles on word 3 → `mem_req` and `mem_addr`=0x1043 are stable throughout. Data order and count are unchanged.
- Stale address: after word 10 delivered, change `ram_address` to 0x2000 while in WAIT → response dropped, no `word_ready`. A new refill starts at 0x2000 with `cnt`=0.
- DONE hold: keep `cache_miss`=1 with the same address for 4 cycles after `refill_done` → no `mem_req` issued. Drop `cache_miss` → `busy`=0 the next cycle.
- Async reset at word 30: pulse `nrst` low mid-WAIT → outputs 0 immediately. A late `mem_rvalid` after release produces no `word_ready`.
